// File: rtl/voice_mixer.sv
// N-voice sample mixer: collects one sample per active voice each frame, sums them and divides
// by the active-voice count with a bit-serial restoring divider.
module voice_mixer #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned SAMPLE_W   = 9
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sample_now,
  input  logic [NUM_VOICES-1:0]          active,
  input  logic [NUM_VOICES-1:0]          done_in,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0]            mix_out,
  output logic                           ready,
  output logic                           missed,
  output logic                           busy
);

  localparam int unsigned SUM_W = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int unsigned CNT_W = $clog2(SUM_W + NUM_VOICES + 1);
  localparam logic [CNT_W-1:0] AccLast = CNT_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0] DivLast = CNT_W'(SUM_W - 1);

  typedef enum logic [2:0] {StIdle, StCollect, StAccum, StDivide, StOutput} state_e;

  state_e                    state_q, state_d;
  logic [NUM_VOICES-1:0]     mask_q, mask_d;
  logic [NUM_VOICES-1:0]     got_q, got_d;
  logic [SAMPLE_W-1:0]       samp_q [NUM_VOICES];
  logic [SAMPLE_W-1:0]       samp_d [NUM_VOICES];
  logic [SUM_W-1:0]          sum_q, sum_d;
  logic [SUM_W-1:0]          rem_q, rem_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      pending_q, pending_d;
  logic [SAMPLE_W-1:0]       mix_q, mix_d;

  logic [SUM_W-1:0]          divisor;
  logic [SUM_W:0]            rem_shift;
  logic [SUM_W:0]            rem_diff;
  logic                      quo_bit;

  always_comb begin
    divisor = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      divisor = divisor + {{(SUM_W-1){1'b0}}, mask_q[i]};
    end
  end

  // Remainder never reaches 2^SUM_W, so the borrow bit of the difference is the compare result.
  assign rem_shift = {rem_q, sum_q[SUM_W-1]};
  assign rem_diff  = rem_shift - {1'b0, divisor};
  assign quo_bit   = ~rem_diff[SUM_W];

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    got_d     = got_q;
    samp_d    = samp_q;
    sum_d     = sum_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    mix_d     = mix_q;
    missed    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sample_now) begin
          mask_d = active;
          got_d  = '0;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (active[i] && done_in[i]) begin
              samp_d[i] = sample_in[i*SAMPLE_W +: SAMPLE_W];
              got_d[i]  = 1'b1;
            end
          end
          if (active == '0) begin
            mix_d   = '0;
            state_d = StOutput;
          end else begin
            state_d = StCollect;
          end
        end
      end

      StCollect: begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (mask_q[i] && done_in[i]) begin
            samp_d[i] = sample_in[i*SAMPLE_W +: SAMPLE_W];
            got_d[i]  = 1'b1;
          end
        end
        sum_d = '0;
        cnt_d = '0;
        if (((got_q | done_in) & mask_q) == mask_q) begin
          // A frame start coinciding with completion still opens the next frame.
          if (sample_now) pending_d = 1'b1;
          if (mask_q == '0) begin
            mix_d   = '0;
            state_d = StOutput;
          end else begin
            state_d = StAccum;
          end
        end else if (sample_now) begin
          missed    = 1'b1;
          pending_d = 1'b1;
          state_d   = StAccum;
        end
      end

      StAccum: begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (cnt_q == i[CNT_W-1:0] && mask_q[i] && got_q[i]) begin
            sum_d = sum_q + {{(SUM_W-SAMPLE_W){1'b0}}, samp_q[i]};
          end
        end
        if (cnt_q == AccLast) begin
          cnt_d   = '0;
          rem_d   = '0;
          state_d = StDivide;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StDivide: begin
        sum_d = {sum_q[SUM_W-2:0], quo_bit};
        rem_d = quo_bit ? rem_diff[SUM_W-1:0] : rem_shift[SUM_W-1:0];
        if (cnt_q == DivLast) begin
          mix_d   = sum_d[SAMPLE_W-1:0];
          state_d = StOutput;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StOutput: begin
        if (pending_q) begin
          pending_d = 1'b0;
          mask_d    = active;
          got_d     = '0;
          state_d   = StCollect;
        end else begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      got_q     <= '0;
      sum_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      mix_q     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        samp_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      got_q     <= got_d;
      sum_q     <= sum_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      mix_q     <= mix_d;
      samp_q    <= samp_d;
    end
  end

  assign mix_out = mix_q;
  assign ready   = (state_q == StOutput);
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: stimulus pushes expected mixes into a scoreboard queue, a
// negedge monitor pops and checks them whenever ready is presented.
module tb_voice_mixer;
  localparam int NV = 4;
  localparam int SW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_now;
  logic [NV-1:0] active;
  logic [NV-1:0] done_in;
  logic [NV*SW-1:0] sample_in;
  logic [SW-1:0] mix_out;
  logic          ready;
  logic          missed;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int missed_seen = 0;
  bit mon_en = 1'b0;
  int exp_mix[$];
  int exp_cyc[$];

  always #5 clk = ~clk;

  voice_mixer #(
    .NUM_VOICES(NV),
    .SAMPLE_W  (SW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_now(sample_now),
    .active    (active),
    .done_in   (done_in),
    .sample_in (sample_in),
    .mix_out   (mix_out),
    .ready     (ready),
    .missed    (missed),
    .busy      (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    int m;
    int c;
    if (mon_en) begin
      if (missed) missed_seen++;
      if (ready) begin
        check("ready_missed_exclusive", int'(missed), 0);
        if (exp_mix.size() == 0) begin
          check("unexpected_ready", 1, 0);
        end else begin
          m = exp_mix.pop_front();
          c = exp_cyc.pop_front();
          check("mix_out", int'(mix_out), m);
          if (c >= 0) check("ready_latency", cyc, c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_v(input int i, input int v);
    sample_in[i*SW +: SW] = SW'(v);
  endtask

  task automatic push(input int m, input int c);
    exp_mix.push_back(m);
    exp_cyc.push_back(c);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_mix.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_mix.size() != 0) begin
      check(name, exp_mix.size(), 0);
      exp_mix.delete();
      exp_cyc.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    reset      = 1'b1;
    sample_now = 1'b0;
    active     = '0;
    done_in    = '0;
    sample_in  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_mix_out", int'(mix_out), 0);
    check("reset_ready", int'(ready), 0);
    check("reset_missed", int'(missed), 0);
    check("reset_busy", int'(busy), 0);
    mon_en = 1'b1;

    // Two voices, staggered delivery: (100+200)/2
    active = 4'b0011;
    sample_now = 1'b1;
    tick();
    sample_now = 1'b0;
    done_in = 4'b0001;
    set_v(0, 100);
    tick();
    done_in = '0;
    tick();
    done_in = 4'b0010;
    set_v(1, 200);
    push(150, cyc + 16);
    tick();
    done_in = '0;
    drain("t1_drain");

    // Delivery in the same cycle as the frame start
    active = 4'b0001;
    sample_now = 1'b1;
    done_in = 4'b0001;
    set_v(0, 511);
    push(511, -1);
    tick();
    sample_now = 1'b0;
    done_in = '0;
    drain("t2_drain");

    // Truncation: 2043/4
    active = 4'b1111;
    sample_now = 1'b1;
    tick();
    sample_now = 1'b0;
    done_in = 4'b1111;
    set_v(0, 511);
    set_v(1, 511);
    set_v(2, 511);
    set_v(3, 510);
    push(510, cyc + 16);
    tick();
    done_in = '0;
    drain("t3_drain");

    // Duplicate overwrite and an unmasked voice: (40+50+60)/3
    active = 4'b0111;
    sample_now = 1'b1;
    tick();
    sample_now = 1'b0;
    done_in = 4'b1001;
    set_v(0, 10);
    set_v(3, 500);
    tick();
    done_in = 4'b0001;
    set_v(0, 40);
    tick();
    done_in = 4'b0110;
    set_v(1, 50);
    set_v(2, 60);
    push(50, cyc + 16);
    tick();
    done_in = '0;
    drain("t3b_drain");

    // Empty mask
    active = 4'b0000;
    sample_now = 1'b1;
    push(0, cyc + 1);
    tick();
    sample_now = 1'b0;
    check("t4_busy_output", int'(busy), 1);
    tick();
    check("t4_busy_after", int'(busy), 0);
    drain("t4_drain");

    // Missed voice: voice 2 silent, second frame start closes the frame; (300+300+0)/3
    active = 4'b0111;
    sample_now = 1'b1;
    tick();
    sample_now = 1'b0;
    done_in = 4'b0011;
    set_v(0, 300);
    set_v(1, 300);
    tick();
    done_in = '0;
    tick();
    tick();
    sample_now = 1'b1;
    active = 4'b0010;
    #1;
    check("t5_missed", int'(missed), 1);
    c = cyc;
    push(200, c + 16);
    tick();
    sample_now = 1'b0;
    while (cyc < c + 17) tick();
    check("t5_busy_new_frame", int'(busy), 1);
    done_in = 4'b0010;
    set_v(1, 77);
    push(77, cyc + 16);
    tick();
    done_in = '0;
    drain("t5_drain");

    // Reset in the middle of DIVIDE
    active = 4'b0001;
    sample_now = 1'b1;
    done_in = 4'b0001;
    set_v(0, 5);
    c = cyc;
    tick();
    sample_now = 1'b0;
    done_in = '0;
    while (cyc < c + 8) tick();
    check("t6_busy_divide", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_mix_out", int'(mix_out), 0);
    check("t6_ready", int'(ready), 0);
    check("t6_missed", int'(missed), 0);
    check("t6_busy", int'(busy), 0);
    done_in = 4'b0001;
    set_v(0, 9);
    tick();
    done_in = '0;
    for (int k = 0; k < 4; k++) begin
      check("t6_busy_idle", int'(busy), 0);
      tick();
    end
    for (int k = 0; k < 20; k++) tick();

    check("missed_count", missed_seen, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Parametrised N-voice sample mixer replacing the fixed two-input waveform combiner in the synthesizer datapath. Once per audio frame (marked by the sample-rate pulse) it collects one sample from every active soundpath voice, sums them, and divides the sum by the number of active voices. It presents the averaged sample with a one-cycle `ready` strobe to the PWM stage. Voices that miss the frame are detected and flagged.

## Interface
- `NUM_VOICES`, default 4: number of voice inputs (2..8).
- `SAMPLE_W`, default 9: width of each unsigned voice sample and of `mix_out`.
- `SUM_W` (derived, not overridable): SAMPLE_W + $clog2(NUM_VOICES); 11 at defaults.

Ports:
- `clk` in 1: system clock (hwclk domain).
- `reset` in 1: synchronous, active-high reset.
- `sample_now` in 1: one-cycle frame-start pulse from the rate divider.
- `active` in NUM_VOICES: voice enable mask; bit i = voice i currently sounding.
- `done_in` in NUM_VOICES: per-voice one-cycle sample-valid pulse.
- `sample_in` in NUM_VOICES*SAMPLE_W: voice i at bits [i*SAMPLE_W +: SAMPLE_W].
- `mix_out` out SAMPLE_W: registered averaged sample; held between frames.
- `ready` out 1: one-cycle pulse; `mix_out` is new in this cycle.
- `missed` out 1: one-cycle pulse; a frame closed with at least one active voice undelivered.
- `busy` out 1: high whenever state != IDLE.

## Operation
- States: IDLE, COLLECT, ACCUM, DIVIDE, OUTPUT.
- IDLE:
  - On `sample_now`, capture `active` into `mask` and clear the per-voice `got` bits.
  - A `done_in` bit in that same cycle is latched as if received in COLLECT.
  - Next state is OUTPUT if `mask` is 0, else COLLECT.
- COLLECT:
  - For each i with mask[i] & done_in[i], latch sample i and set got[i]. Duplicates overwrite.
  - done_in for unmasked voices is ignored.
  - When (got | this-cycle done) covers `mask`, go to ACCUM.
  - `sample_now` before completion: close the frame. Undelivered voices contribute 0 but still count in the divisor. Pulse `missed` in that cycle, set `pending` and go to ACCUM.
- ACCUM:
  - Exactly NUM_VOICES cycles; cycle k adds latched[k] to `sum` when mask[k].
  - `sum` is SUM_W bits wide and cannot overflow.
  - `count` = popcount(mask).
- DIVIDE:
  - Restoring divide sum / count, exactly SUM_W cycles, one quotient bit per cycle, MSB first.
  - The quotient truncates toward zero and is always ≤ 2^SAMPLE_W − 1.
- OUTPUT:
  - One cycle: `mix_out` = quotient (0 for an empty mask), `ready` = 1.
  - If `pending` is set: clear it, capture the current `active` into `mask`, clear `got` and go to COLLECT (the frame that closed the previous one). Otherwise go to IDLE.
- `done_in` and `sample_now` arriving in ACCUM/DIVIDE/OUTPUT are ignored, except for the pending start recorded in COLLECT.
- `active` changes mid-frame have no effect until the next capture.

## Timing
- Reset values: state IDLE, `mix_out` 0, `ready` 0, `missed` 0, `busy` 0, `pending` 0, all latches 0.
- Reset asserted mid-operation aborts the frame at the next edge; no `ready` is issued for it.
- Latency, with the last required `done_in` sampled in cycle T:
  - ACCUM occupies T+1..T+NUM_VOICES.
  - DIVIDE occupies the next SUM_W cycles.
  - `ready` is high in cycle T+NUM_VOICES+SUM_W+1 (T+16 at defaults).
- Empty mask: `ready` is high in the cycle after `sample_now`, with `mix_out` 0.
- `missed` and `ready` are never high in the same cycle for the same frame.
- Throughput: one frame per NUM_VOICES+SUM_W+2 cycles minimum; the rate divider period is always far longer.

## Test plan
- N=4, active=0011; voice0 done with 100, voice1 done with 200 two cycles later -> `mix_out`=150, `ready` 16 cycles after voice1's done, `missed` never high.
- active=0001; voice0 = 511 in the same cycle as `sample_now` -> `mix_out`=511 (same-cycle capture honoured).
- active=1111 with samples 511,511,511,510 -> sum 2043, `mix_out`=510 (truncation).
- active=0000, `sample_now` -> `ready` next cycle, `mix_out`=0, `busy` high for exactly 1 cycle.
- active=0111; voices 0 and 1 deliver 300, voice 2 silent; second `sample_now` arrives -> `missed` pulse that cycle, `mix_out`=200. The FSM then enters COLLECT for the new frame without a further `sample_now`.
- Reset asserted during DIVIDE -> next cycle all outputs 0 and state IDLE, no `ready`. A subsequent `done_in` without `sample_now` is ignored (`busy` stays 0).
